// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the SRAM sequencer: one-hot state encoding (also
// decoded by the HEX status display) and strobe decode helpers.
package mem_ctrl_pkg;

  localparam int unsigned STATE_W = 13;
  localparam int unsigned DATA_W  = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET      = 13'h0001,
    ST_IDLE       = 13'h0002,
    ST_READ_ST0   = 13'h0004,
    ST_READ_ST1   = 13'h0008,
    ST_READ_ST2   = 13'h0010,
    ST_READ_WAIT  = 13'h0020,
    ST_READ_DONE  = 13'h0040,
    ST_WRITE_ST0  = 13'h0080,
    ST_WRITE_ST1  = 13'h0100,
    ST_WRITE_ST2  = 13'h0200,
    ST_WRITE_ST3  = 13'h0400,
    ST_WRITE_ST4  = 13'h0800,
    ST_WRITE_WAIT = 13'h1000
  } state_t;

  // Chip select is held for the whole device cycle; WRITE_ST0 only sets up
  // address/data, so select starts one state later on writes.
  function automatic logic cs_active(input state_t s);
    logic act;
    case (s)
      ST_READ_ST0, ST_READ_ST1, ST_READ_ST2, ST_READ_WAIT,
      ST_WRITE_ST1, ST_WRITE_ST2, ST_WRITE_ST3, ST_WRITE_ST4,
      ST_WRITE_WAIT: act = 1'b1;
      default:       act = 1'b0;
    endcase
    return act;
  endfunction

  function automatic logic oe_active(input state_t s);
    logic act;
    case (s)
      ST_READ_ST1, ST_READ_ST2, ST_READ_WAIT: act = 1'b1;
      default:                                act = 1'b0;
    endcase
    return act;
  endfunction

  // Write strobe is a fixed two-cycle pulse, disjoint from the read states,
  // so we_n and oe_n can never be low together.
  function automatic logic we_active(input state_t s);
    logic act;
    case (s)
      ST_WRITE_ST2, ST_WRITE_ST3: act = 1'b1;
      default:                    act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/mem_ctrl_fsm_wait_timer.sv
// Clearable up-counter with a terminal-count flag; shared by the power-up
// settle delay and the device ack timeout.
module wait_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             done
);

  logic [WIDTH-1:0] count_r;

  // Count register: clear has priority over enable, otherwise hold.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_r <= {WIDTH{1'b0}};
    end else if (enable) begin
      count_r <= count_r + WIDTH'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == limit);

endmodule

// File: rtl/mem_ctrl_fsm.sv
// SRAM-style memory sequencer: accepts one request in IDLE, walks fixed
// setup/strobe/hold phases, waits for the device ack with a timeout and
// exports its one-hot state plus the last read word for the status display.
module mem_ctrl_fsm
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned RESET_CYC = 8,
  parameter int unsigned WAIT_MAX  = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               req_ready,
  input  logic               rsp_ack,
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic               err_timeout,
  output logic [STATE_W-1:0] state,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               mem_cs_n,
  output logic               mem_oe_n,
  output logic               mem_we_n,
  input  logic               mem_ack
);

  localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);
  localparam int unsigned RST_W  = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;
  localparam int unsigned TMR_W  = (WAIT_W > RST_W) ? WAIT_W : RST_W;
  localparam logic [TMR_W-1:0] RST_LIMIT  = TMR_W'(RESET_CYC - 1);
  localparam logic [TMR_W-1:0] WAIT_LIMIT = TMR_W'(WAIT_MAX);

  state_t             state_r, next_s;
  logic               tmr_clear_s, tmr_en_s, tmr_done_s;
  logic [TMR_W-1:0]   tmr_limit_s;
  logic               accept_s, capture_s, timeout_s;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [DATA_W-1:0]  mem_wdata_r, rsp_rdata_r;
  logic               err_timeout_r, cs_n_r, oe_n_r, we_n_r;
  logic               req_ready_r, rsp_valid_r;

  wait_timer #(.WIDTH(TMR_W)) u_timer (
    .clk    (clk),
    .clear  (tmr_clear_s),
    .enable (tmr_en_s),
    .limit  (tmr_limit_s),
    .done   (tmr_done_s)
  );

  // Next-state, timer control and datapath load enables.
  always_comb begin
    next_s      = state_r;
    tmr_clear_s = 1'b0;
    tmr_en_s    = 1'b0;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    timeout_s   = 1'b0;
    tmr_limit_s = (state_r == ST_RESET) ? RST_LIMIT : WAIT_LIMIT;
    if (reset) begin
      next_s      = ST_RESET;
      tmr_clear_s = 1'b1;
    end else begin
      case (state_r)
        ST_RESET: begin
          if (tmr_done_s) next_s = ST_IDLE;
          else            tmr_en_s = 1'b1;
        end
        ST_IDLE: begin
          if (req_valid) begin
            accept_s = 1'b1;
            next_s   = req_write ? ST_WRITE_ST0 : ST_READ_ST0;
          end else begin
            next_s = ST_IDLE;
          end
        end
        ST_READ_ST0: next_s = ST_READ_ST1;
        ST_READ_ST1: next_s = ST_READ_ST2;
        ST_READ_ST2: begin
          tmr_clear_s = 1'b1;
          next_s      = ST_READ_WAIT;
        end
        // Ack is tested before the timer so a same-cycle ack still succeeds.
        ST_READ_WAIT: begin
          if (mem_ack) begin
            capture_s = 1'b1;
            next_s    = ST_READ_DONE;
          end else if (tmr_done_s) begin
            timeout_s = 1'b1;
            next_s    = ST_IDLE;
          end else begin
            tmr_en_s = 1'b1;
          end
        end
        ST_READ_DONE: begin
          if (rsp_ack) next_s = ST_IDLE;
          else         next_s = ST_READ_DONE;
        end
        ST_WRITE_ST0: next_s = ST_WRITE_ST1;
        ST_WRITE_ST1: next_s = ST_WRITE_ST2;
        ST_WRITE_ST2: next_s = ST_WRITE_ST3;
        ST_WRITE_ST3: next_s = ST_WRITE_ST4;
        ST_WRITE_ST4: begin
          tmr_clear_s = 1'b1;
          next_s      = ST_WRITE_WAIT;
        end
        ST_WRITE_WAIT: begin
          if (mem_ack) begin
            next_s = ST_IDLE;
          end else if (tmr_done_s) begin
            timeout_s = 1'b1;
            next_s    = ST_IDLE;
          end else begin
            tmr_en_s = 1'b1;
          end
        end
        default: begin
          next_s      = ST_RESET;
          tmr_clear_s = 1'b1;
        end
      endcase
    end
  end

  // State and registered outputs; strobes decode the next state so they
  // change on the same edge as the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_RESET;
      mem_addr_r    <= {ADDR_W{1'b0}};
      mem_wdata_r   <= 16'h0000;
      rsp_rdata_r   <= 16'h0000;
      err_timeout_r <= 1'b0;
      cs_n_r        <= 1'b1;
      oe_n_r        <= 1'b1;
      we_n_r        <= 1'b1;
      req_ready_r   <= 1'b0;
      rsp_valid_r   <= 1'b0;
    end else begin
      state_r     <= next_s;
      cs_n_r      <= ~cs_active(next_s);
      oe_n_r      <= ~oe_active(next_s);
      we_n_r      <= ~we_active(next_s);
      req_ready_r <= (next_s == ST_IDLE);
      rsp_valid_r <= (next_s == ST_READ_DONE);
      if (accept_s) begin
        mem_addr_r  <= req_addr;
        mem_wdata_r <= req_wdata;
      end else begin
        mem_addr_r  <= mem_addr_r;
        mem_wdata_r <= mem_wdata_r;
      end
      if (capture_s) rsp_rdata_r <= mem_rdata;
      else           rsp_rdata_r <= rsp_rdata_r;
      if (accept_s)       err_timeout_r <= 1'b0;
      else if (timeout_s) err_timeout_r <= 1'b1;
      else                err_timeout_r <= err_timeout_r;
    end
  end

  assign state       = state_r;
  assign req_ready   = req_ready_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign err_timeout = err_timeout_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wdata   = mem_wdata_r;
  assign mem_cs_n    = cs_n_r;
  assign mem_oe_n    = oe_n_r;
  assign mem_we_n    = we_n_r;

endmodule

// File: tb/tb_mem_ctrl_fsm.sv
// Directed bench for mem_ctrl_fsm with a small SRAM device model and
// read/write scoreboards.
module tb_mem_ctrl_fsm;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned RESET_CYC = 8;
  localparam int unsigned WAIT_MAX  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_wdata;
  logic              req_ready;
  logic              rsp_ack, rsp_valid;
  logic [15:0]       rsp_rdata;
  logic              err_timeout;
  logic [12:0]       state;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata, mem_rdata;
  logic              mem_cs_n, mem_oe_n, mem_we_n, mem_ack;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_rd_q[$];
  logic [31:0] exp_wr_q[$];

  // Device model state
  int          cs_cnt = 0;
  int          ack_after;
  logic        ack_en;
  logic        prev_we_n = 1'b1;
  int          we_low_cnt = 0;
  int          overlap_cnt = 0;
  int          cs_viol_cnt = 0;
  int          wr_seen_n = 0;
  logic [31:0] last_wr = 32'h0;
  int          we_base, wr_base;

  always #5 clk = ~clk;

  mem_ctrl_fsm #(.ADDR_W(ADDR_W), .RESET_CYC(RESET_CYC), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_ack(rsp_ack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .err_timeout(err_timeout), .state(state), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_cs_n(mem_cs_n),
    .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .mem_ack(mem_ack)
  );

  // Device acks once chip select has been low for ack_after cycles.
  assign mem_ack = ack_en && !mem_cs_n && (cs_cnt >= ack_after);

  always @(posedge clk) cs_cnt <= mem_cs_n ? 0 : cs_cnt + 1;

  // Pin monitor: strobe rules and write completion (we_n rising while selected).
  always @(posedge clk) begin
    #1;
    if (!mem_we_n) we_low_cnt++;
    if (!mem_we_n && !mem_oe_n) overlap_cnt++;
    if ((!mem_we_n || !mem_oe_n) && mem_cs_n) cs_viol_cnt++;
    if (!prev_we_n && mem_we_n && !mem_cs_n) begin
      last_wr = {mem_addr, mem_wdata};
      wr_seen_n++;
    end
    prev_we_n = mem_we_n;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [12:0] st, input int budget, input string tag);
    int k = 0;
    while (state !== st && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(state), 32'(st));
  endtask

  task automatic check_rd(input string tag);
    if (exp_rd_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed=%h expected=<empty scoreboard>", tag, rsp_rdata);
    end else begin
      chk(tag, 32'(rsp_rdata), 32'(exp_rd_q.pop_front()));
    end
  endtask

  task automatic check_wr(input string tag);
    if (exp_wr_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed=%h expected=<empty scoreboard>", tag, last_wr);
    end else begin
      chk(tag, last_wr, exp_wr_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0;
    req_wdata = 16'h0; rsp_ack = 1'b0; mem_rdata = 16'h0;
    ack_en = 1'b0; ack_after = 0;
    repeat (3) step();
    chk("rst_state",   32'(state), 32'h0001);
    chk("rst_strobes", 32'({mem_cs_n, mem_oe_n, mem_we_n}), 32'h7);
    chk("rst_addr",    32'(mem_addr), 32'h0);
    chk("rst_rdata",   32'(rsp_rdata), 32'h0);
    chk("rst_err",     32'(err_timeout), 32'h0);
    chk("rst_ready",   32'(req_ready), 32'h0);

    // Power-up settle: RESET for RESET_CYC cycles after the last reset edge.
    reset = 1'b0;
    for (int i = 1; i < RESET_CYC; i++) begin
      step();
      chk("reset_hold", 32'(state), 32'h0001);
    end
    step();
    chk("idle_after_reset", 32'(state), 32'h0002);
    chk("ready_in_idle",    32'(req_ready), 32'h1);
    chk("idle_strobes",     32'({mem_cs_n, mem_oe_n, mem_we_n}), 32'h7);

    // Read 0x1234, device acks after 3 wait cycles with 0xBEEF.
    ack_en = 1'b1; ack_after = 6; mem_rdata = 16'hBEEF;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h1234; req_wdata = 16'h5555;
    exp_rd_q.push_back(16'hBEEF);
    step();
    req_valid = 1'b0;
    chk("rd_st0",      32'(state), 32'h0004);
    chk("rd_addr",     32'(mem_addr), 32'h1234);
    chk("rd_st0_strb", 32'({mem_cs_n, mem_oe_n, mem_we_n}), 32'h3);
    chk("rd_not_ready", 32'(req_ready), 32'h0);
    step();
    chk("rd_st1",      32'(state), 32'h0008);
    chk("rd_st1_strb", 32'({mem_cs_n, mem_oe_n, mem_we_n}), 32'h1);
    step();
    chk("rd_st2",      32'(state), 32'h0010);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rd_wait", 32'(state), 32'h0020);
    end
    step();
    chk("rd_done",      32'(state), 32'h0040);
    chk("rd_valid",     32'(rsp_valid), 32'h1);
    chk("rd_done_strb", 32'({mem_cs_n, mem_oe_n, mem_we_n}), 32'h7);
    check_rd("rd_data");

    // Request held during READ_DONE must wait for IDLE.
    mem_rdata = 16'h0BAD; ack_after = 0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_wdata = 16'hA5A5;
    exp_wr_q.push_back({16'h0010, 16'hA5A5});
    for (int i = 0; i < 2; i++) begin
      step();
      chk("done_hold",    32'(state), 32'h0040);
      chk("done_no_ready", 32'(req_ready), 32'h0);
    end
    chk("rdata_held", 32'(rsp_rdata), 32'hBEEF);
    rsp_ack = 1'b1;
    step();
    rsp_ack = 1'b0;
    chk("idle_after_ack", 32'(state), 32'h0002);
    chk("valid_dropped",  32'(rsp_valid), 32'h0);
    we_base = we_low_cnt;

    // Write 0x0010 <= 0xA5A5, device acks immediately.
    step();
    req_valid = 1'b0;
    chk("wr_st0",      32'(state), 32'h0080);
    chk("wr_addr",     32'(mem_addr), 32'h0010);
    chk("wr_data",     32'(mem_wdata), 32'hA5A5);
    chk("wr_st0_strb", 32'({mem_cs_n, mem_oe_n, mem_we_n}), 32'h7);
    step(); chk("wr_st1", 32'(state), 32'h0100);
    chk("wr_st1_strb", 32'({mem_cs_n, mem_oe_n, mem_we_n}), 32'h3);
    step(); chk("wr_st2", 32'(state), 32'h0200);
    chk("wr_st2_strb", 32'({mem_cs_n, mem_oe_n, mem_we_n}), 32'h2);
    step(); chk("wr_st3", 32'(state), 32'h0400);
    chk("wr_st3_strb", 32'({mem_cs_n, mem_oe_n, mem_we_n}), 32'h2);
    step(); chk("wr_st4", 32'(state), 32'h0800);
    chk("wr_st4_strb", 32'({mem_cs_n, mem_oe_n, mem_we_n}), 32'h3);
    step(); chk("wr_wait", 32'(state), 32'h1000);
    step(); chk("wr_idle", 32'(state), 32'h0002);
    chk("wr_idle_strb", 32'({mem_cs_n, mem_oe_n, mem_we_n}), 32'h7);
    chk("we_low_cycles", 32'(we_low_cnt - we_base), 32'd2);
    chk("wr_count",      32'(wr_seen_n), 32'd1);
    check_wr("wr_stored");

    // Timeout: no ack, rsp_rdata must keep the previous word.
    ack_en = 1'b0; mem_rdata = 16'h1111;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0042;
    step();
    req_valid = 1'b0;
    chk("to_st0", 32'(state), 32'h0004);
    wait_state(13'h0002, 20, "timeout_to_idle");
    chk("to_err",   32'(err_timeout), 32'h1);
    chk("to_rdata", 32'(rsp_rdata), 32'hBEEF);
    chk("to_valid", 32'(rsp_valid), 32'h0);

    // Ack on the final wait cycle wins; new request clears err_timeout.
    ack_en = 1'b1; ack_after = 7; mem_rdata = 16'h2222;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0043;
    exp_rd_q.push_back(16'h2222);
    step();
    req_valid = 1'b0;
    chk("err_cleared", 32'(err_timeout), 32'h0);
    wait_state(13'h0040, 20, "ackwin_done");
    check_rd("ackwin_data");
    chk("ackwin_err", 32'(err_timeout), 32'h0);
    rsp_ack = 1'b1;
    step();
    rsp_ack = 1'b0;
    chk("ackwin_idle", 32'(state), 32'h0002);

    // rsp_ack in IDLE is ignored.
    rsp_ack = 1'b1;
    step();
    rsp_ack = 1'b0;
    chk("ack_idle_state", 32'(state), 32'h0002);
    chk("ack_idle_valid", 32'(rsp_valid), 32'h0);

    // Reset during WRITE_ST2 aborts without completing the write.
    ack_after = 0; wr_base = wr_seen_n;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'h7777;
    step();
    req_valid = 1'b0;
    wait_state(13'h0200, 10, "abort_reach_st2");
    chk("abort_we_low", 32'(mem_we_n), 32'h0);
    reset = 1'b1;
    step();
    chk("abort_state",   32'(state), 32'h0001);
    chk("abort_strobes", 32'({mem_cs_n, mem_oe_n, mem_we_n}), 32'h7);
    chk("abort_addr",    32'(mem_addr), 32'h0);
    reset = 1'b0;
    repeat (3) step();
    chk("abort_no_write", 32'(wr_seen_n - wr_base), 32'd0);
    wait_state(13'h0002, 20, "abort_back_idle");
    chk("no_oe_we_overlap", 32'(overlap_cnt), 32'd0);
    chk("cs_covers_strobes", 32'(cs_viol_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
